riscv_run_ctrl: RTL and testbench
=================================

Name: riscv_run_ctrl

Overview:
- Sits directly downstream of the RISC-V AXI4-Lite slave register block and consumes its decoded control outputs.
- Sequences a core run that lasts a programmed number of cycles, and reports idle/running/done status back to the register block.
- Converts instruction-write ticks into a registered, range-checked write port for the core's instruction memory.
- Drives the core's clock-enable and reset.

Parameters:
- IMEM_ADDR_W, 10, instruction-memory word-address width; depth = 2^IMEM_ADDR_W words.
- DATA_W, 32, instruction word width.

Ports:
- S_AXI_ACLK  in  1  single clock, shared with the AXI4-Lite slave.
- S_AXI_ARESET  in  1  synchronous, active-high reset.
- i_run  in  1  one-cycle start tick.
- i_num_cycle  in  32  number of core-enabled cycles per run.
- i_mem_reset_n  in  1  level, active-low; requests core reset and aborts a run.
- i_instruction_write  in  1  one-cycle instruction-write tick.
- i_instr_addr  in  32  byte address of the instruction write.
- i_instr_data  in  DATA_W  instruction word to write.
- o_idle  out  1  high in IDLE.
- o_running  out  1  high in RUN.
- o_done  out  1  one-cycle tick at run completion.
- o_core_en  out  1  core clock-enable.
- o_core_rst  out  1  active-high core reset.
- o_cycle_count  out  32  number of enabled cycles in the current or last run.
- o_imem_we  out  1  instruction-memory write enable.
- o_imem_addr  out  IMEM_ADDR_W  word address.
- o_imem_wdata  out  DATA_W  write data.
- o_wr_err  out  1  sticky rejected-write flag.

Behaviour:
- Reset (S_AXI_ARESET=1 at a clock edge):
  - state=IDLE, o_idle=1, o_core_rst=1.
  - All other outputs 0, counters 0.
- FSM states: IDLE, RUN, DONE. All outputs are registered.
- IDLE:
  - i_run=1 and i_mem_reset_n=1 -> RUN next cycle.
  - On that transition: latch i_num_cycle into the remaining counter; clear o_cycle_count.
- RUN:
  - o_core_en=1 every cycle; o_cycle_count increments by 1 per RUN cycle.
  - Remaining counter decrements each cycle; after exactly N RUN cycles (N = latched value) -> DONE.
- DONE:
  - Lasts exactly one cycle; o_done=1 for that cycle only, o_core_en=0.
  - Then -> IDLE.
- Run timing: i_run at cycle t gives:
  - o_running=1 and o_core_en=1 for cycles t+1..t+N;
  - o_done=1 at t+N+1;
  - o_idle=1 from t+N+2.
- N=0: state goes to DONE at t+1 (no RUN cycles, o_core_en never set); o_done at t+1; o_cycle_count=0.
- o_cycle_count holds its final value after DONE until the next run start. A full 2^32-1 run must not wrap.
- i_run outside IDLE is ignored; no restart, no error.
- i_mem_reset_n=0:
  - o_core_rst=1 on the next cycle, tracking ~i_mem_reset_n with one-cycle latency.
  - In RUN, aborts to IDLE next cycle: o_core_en=0, no o_done, o_cycle_count holds the partial count.
  - i_run is ignored while i_mem_reset_n=0.
- i_num_cycle changes after the run tick do not affect a run in progress.
- Instruction writes:
  - Inputs sampled on the cycle i_instruction_write=1. If accepted, o_imem_we=1 for exactly one cycle at the next cycle.
  - o_imem_addr = i_instr_addr[IMEM_ADDR_W+1:2]; o_imem_wdata = i_instr_data. Both hold their last value when o_imem_we=0.
- Write rejection: any of the following rejects the write (o_imem_we stays 0) and sets o_wr_err=1:
  - i_instr_addr[1:0] != 0;
  - i_instr_addr >= 4*2^IMEM_ADDR_W;
  - state != IDLE.
- o_wr_err clears only on reset or an accepted i_run.
- Simultaneous events in IDLE:
  - i_run and i_instruction_write in the same cycle: the write is evaluated as IDLE and accepted if otherwise valid; the run starts.
  - An error set and an error clear in the same cycle: set wins.
- Reset mid-run: the next cycle shows the reset values, with no o_done tick.

Test Plan:
- Run N=3: reset, i_mem_reset_n=1, i_num_cycle=3, i_run tick at t -> o_core_en high t+1..t+3, o_done tick at t+4, o_idle at t+5, o_cycle_count=3.
- Zero cycles: i_num_cycle=0, i_run at t -> o_done at t+1, o_core_en never high, o_cycle_count=0.
- Abort: N=100, i_mem_reset_n=0 at t+10 -> IDLE at t+11, o_core_rst=1, no o_done, o_cycle_count=10. A following i_run while i_mem_reset_n=0 is ignored.
- Valid write: i_instr_addr=0x0000_0010, i_instr_data=0x0000_0093, tick -> next cycle o_imem_we=1, o_imem_addr=4, o_imem_wdata=0x93, o_wr_err=0.
- Rejected writes:
  - addr 0x0000_0012 -> no we, o_wr_err=1.
  - addr 0x0000_1000 (IMEM_ADDR_W=10) -> no we.
  - write during RUN -> no we.
  - Next i_run -> o_wr_err=0.
- Ignored restart: i_run re-pulsed during RUN with i_num_cycle=50 -> run length unchanged, exactly one o_done.

Source files
------------

// File: rtl/riscv_run_ctrl.sv
// Run sequencer for the RISC-V core: counts a programmed number of enabled cycles,
// reports idle/running/done, and turns instruction-write ticks into a checked IMEM write port.
module riscv_run_ctrl #(
  parameter int IMEM_ADDR_W = 10,
  parameter int DATA_W      = 32
) (
  input  logic                   S_AXI_ACLK,
  input  logic                   S_AXI_ARESET,
  input  logic                   i_run,
  input  logic [31:0]            i_num_cycle,
  input  logic                   i_mem_reset_n,
  input  logic                   i_instruction_write,
  input  logic [31:0]            i_instr_addr,
  input  logic [DATA_W-1:0]      i_instr_data,
  output logic                   o_idle,
  output logic                   o_running,
  output logic                   o_done,
  output logic                   o_core_en,
  output logic                   o_core_rst,
  output logic [31:0]            o_cycle_count,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [DATA_W-1:0]      o_imem_wdata,
  output logic                   o_wr_err,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] remaining;

  logic addr_ok;
  logic run_start;
  logic wr_ok;
  logic wr_bad;

  // Word-aligned and inside the 4*2^IMEM_ADDR_W byte window.
  assign addr_ok   = (i_instr_addr[1:0] == 2'b00) &&
                     (i_instr_addr[31:IMEM_ADDR_W+2] == '0);
  assign run_start = (state == IDLE) && i_run && i_mem_reset_n;
  assign wr_ok     = i_instruction_write && addr_ok && (state == IDLE);
  assign wr_bad    = i_instruction_write && !(addr_ok && (state == IDLE));
  assign o_state   = state;

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state         <= IDLE;
      remaining     <= '0;
      o_idle        <= 1'b1;
      o_running     <= 1'b0;
      o_done        <= 1'b0;
      o_core_en     <= 1'b0;
      o_core_rst    <= 1'b1;
      o_cycle_count <= '0;
      o_imem_we     <= 1'b0;
      o_imem_addr   <= '0;
      o_imem_wdata  <= '0;
      o_wr_err      <= 1'b0;
    end else begin
      o_core_rst <= ~i_mem_reset_n;
      o_done     <= 1'b0;
      o_imem_we  <= wr_ok;
      if (wr_ok) begin
        o_imem_addr  <= i_instr_addr[IMEM_ADDR_W+1:2];
        o_imem_wdata <= i_instr_data;
      end
      // A rejected write in the same cycle as a run start keeps the flag set.
      if (wr_bad) begin
        o_wr_err <= 1'b1;
      end else if (run_start) begin
        o_wr_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (run_start) begin
            o_cycle_count <= '0;
            remaining     <= i_num_cycle;
            o_idle        <= 1'b0;
            if (i_num_cycle == 32'd0) begin
              state  <= DONE;
              o_done <= 1'b1;
            end else begin
              state     <= RUN;
              o_running <= 1'b1;
              o_core_en <= 1'b1;
            end
          end
        end
        RUN: begin
          // The cycle in which an abort is seen was still core-enabled, so it counts.
          o_cycle_count <= o_cycle_count + 32'd1;
          remaining     <= remaining - 32'd1;
          if (!i_mem_reset_n) begin
            state     <= IDLE;
            o_idle    <= 1'b1;
            o_running <= 1'b0;
            o_core_en <= 1'b0;
          end else if (remaining == 32'd1) begin
            state     <= DONE;
            o_done    <= 1'b1;
            o_running <= 1'b0;
            o_core_en <= 1'b0;
          end
        end
        DONE: begin
          state  <= IDLE;
          o_idle <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          o_idle    <= 1'b1;
          o_running <= 1'b0;
          o_core_en <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_run_ctrl.sv
// Directed bench for riscv_run_ctrl: drivers push expected IMEM writes and done ticks
// into queues; a negedge monitor pops and compares whenever the DUT presents them.
module tb_riscv_run_ctrl;
  localparam int AW = 10;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_run = 1'b0;
  logic [31:0]   i_num_cycle = '0;
  logic          i_mem_reset_n = 1'b1;
  logic          i_instruction_write = 1'b0;
  logic [31:0]   i_instr_addr = '0;
  logic [DW-1:0] i_instr_data = '0;
  logic          o_idle, o_running, o_done, o_core_en, o_core_rst;
  logic [31:0]   o_cycle_count;
  logic          o_imem_we;
  logic [AW-1:0] o_imem_addr;
  logic [DW-1:0] o_imem_wdata;
  logic          o_wr_err;
  logic [1:0]    o_state;

  riscv_run_ctrl #(.IMEM_ADDR_W(AW), .DATA_W(DW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(rst), .i_run(i_run), .i_num_cycle(i_num_cycle),
    .i_mem_reset_n(i_mem_reset_n), .i_instruction_write(i_instruction_write),
    .i_instr_addr(i_instr_addr), .i_instr_data(i_instr_data), .o_idle(o_idle),
    .o_running(o_running), .o_done(o_done), .o_core_en(o_core_en), .o_core_rst(o_core_rst),
    .o_cycle_count(o_cycle_count), .o_imem_we(o_imem_we), .o_imem_addr(o_imem_addr),
    .o_imem_wdata(o_imem_wdata), .o_wr_err(o_wr_err), .o_state(o_state)
  );

  // Clock / cycle counter / watchdog
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  int n_checks = 0;
  int n_pass   = 0;
  logic [AW+DW-1:0] exp_wr_q[$];
  logic [63:0]      exp_done_q[$];
  int t_run;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Monitor / scoreboard
  int en_cnt = 0;
  logic [AW+DW-1:0] wr_e;
  logic [63:0]      done_e;
  always @(negedge clk) begin
    if (!rst) begin
      check("running_vs_core_en", o_running, o_core_en);
      if (o_imem_we) begin
        if (exp_wr_q.size() == 0) check("unexpected_we", o_imem_we, 0);
        else begin
          wr_e = exp_wr_q.pop_front();
          check("imem_addr", o_imem_addr, wr_e[AW+DW-1:DW]);
          check("imem_wdata", o_imem_wdata, wr_e[DW-1:0]);
        end
      end
      if (o_done) begin
        if (exp_done_q.size() == 0) check("unexpected_done", o_done, 0);
        else begin
          done_e = exp_done_q.pop_front();
          check("done_cycle", cyc, done_e[63:32]);
          check("done_count", o_cycle_count, done_e[31:0]);
          check("done_en_cycles", en_cnt, done_e[31:0]);
        end
      end
      if (o_idle) en_cnt = 0;
      else if (o_core_en) en_cnt++;
    end
  end

  // Driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic neg_at(input int c);
    goto(c);
    @(negedge clk);
  endtask

  task automatic tick_run(input logic [31:0] n, input bit exp_done);
    i_num_cycle = n;
    i_run = 1'b1;
    t_run = cyc;
    if (exp_done) exp_done_q.push_back({32'(t_run + int'(n) + 1), n});
    step();
    i_run = 1'b0;
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] data, input bit accept);
    i_instruction_write = 1'b1;
    i_instr_addr = addr;
    i_instr_data = data;
    if (accept) exp_wr_q.push_back({addr[AW+1:2], data});
    step();
    i_instruction_write = 1'b0;
  endtask

  initial begin
    int t;
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_idle", o_idle, 1);
    check("rst_running", o_running, 0);
    check("rst_done", o_done, 0);
    check("rst_core_en", o_core_en, 0);
    check("rst_core_rst", o_core_rst, 1);
    check("rst_count", o_cycle_count, 0);
    check("rst_we", o_imem_we, 0);
    check("rst_addr", o_imem_addr, 0);
    check("rst_wdata", o_imem_wdata, 0);
    check("rst_wr_err", o_wr_err, 0);
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("core_rst_release", o_core_rst, 0);

    // Run N=3
    step();
    tick_run(3, 1);
    t = t_run;
    neg_at(t + 1);
    check("n3_running_t1", o_running, 1);
    check("n3_idle_t1", o_idle, 0);
    neg_at(t + 3);
    check("n3_core_en_t3", o_core_en, 1);
    neg_at(t + 4);
    check("n3_done_t4", o_done, 1);
    check("n3_core_en_t4", o_core_en, 0);
    neg_at(t + 5);
    check("n3_idle_t5", o_idle, 1);
    check("n3_count_hold", o_cycle_count, 3);

    // Zero cycles
    step();
    tick_run(0, 1);
    t = t_run;
    neg_at(t + 1);
    check("n0_done", o_done, 1);
    check("n0_running", o_running, 0);
    check("n0_count", o_cycle_count, 0);
    neg_at(t + 2);
    check("n0_idle", o_idle, 1);

    // Abort at t+10, then a run request while held in core reset
    step();
    tick_run(100, 0);
    t = t_run;
    goto(t + 10);
    i_mem_reset_n = 1'b0;
    neg_at(t + 11);
    check("abort_idle", o_idle, 1);
    check("abort_core_en", o_core_en, 0);
    check("abort_core_rst", o_core_rst, 1);
    check("abort_count", o_cycle_count, 10);
    check("abort_done", o_done, 0);
    step();
    i_run = 1'b1;
    i_num_cycle = 5;
    step();
    i_run = 1'b0;
    @(negedge clk);
    check("held_run_idle", o_idle, 1);
    check("held_run_running", o_running, 0);
    check("held_run_count", o_cycle_count, 10);
    step();
    i_mem_reset_n = 1'b1;
    step();
    @(negedge clk);
    check("core_rst_follow", o_core_rst, 0);

    // Valid write, then we must drop while addr/data hold
    step();
    wr(32'h0000_0010, 32'h0000_0093, 1);
    @(negedge clk);
    check("valid_wr_err", o_wr_err, 0);
    step();
    @(negedge clk);
    check("we_one_cycle", o_imem_we, 0);
    check("addr_hold", o_imem_addr, 4);

    // Rejections and error clearing
    step();
    wr(32'h0000_0012, 32'hdead_beef, 0);
    @(negedge clk);
    check("misaligned_err", o_wr_err, 1);
    step();
    tick_run(2, 1);
    t = t_run;
    @(negedge clk);
    check("run_clears_err", o_wr_err, 0);
    neg_at(t + 4);
    step();
    wr(32'h0000_1000, 32'h1111_2222, 0);
    @(negedge clk);
    check("range_err", o_wr_err, 1);
    step();
    wr(32'h0000_0ffc, 32'h0000_0013, 1);
    @(negedge clk);
    check("err_sticky", o_wr_err, 1);
    step();
    tick_run(5, 1);
    t = t_run;
    goto(t + 2);
    wr(32'h0000_0020, 32'h0000_0055, 0);
    @(negedge clk);
    check("run_write_err", o_wr_err, 1);
    neg_at(t + 7);
    check("n5_idle", o_idle, 1);

    // Run and valid write together: write accepted, run starts, error clears
    step();
    t = cyc;
    i_run = 1'b1;
    i_num_cycle = 1;
    i_instruction_write = 1'b1;
    i_instr_addr = 32'h0000_0040;
    i_instr_data = 32'hcafe_0001;
    exp_wr_q.push_back({10'd16, 32'hcafe_0001});
    exp_done_q.push_back({32'(t + 2), 32'd1});
    step();
    i_run = 1'b0;
    i_instruction_write = 1'b0;
    @(negedge clk);
    check("sim_running", o_running, 1);
    check("sim_err_clear", o_wr_err, 0);
    neg_at(t + 3);

    // Run and rejected write together: set wins
    step();
    t = cyc;
    i_run = 1'b1;
    i_num_cycle = 1;
    i_instruction_write = 1'b1;
    i_instr_addr = 32'h0000_0041;
    exp_done_q.push_back({32'(t + 2), 32'd1});
    step();
    i_run = 1'b0;
    i_instruction_write = 1'b0;
    @(negedge clk);
    check("set_wins_err", o_wr_err, 1);
    neg_at(t + 3);

    // Restart during RUN is ignored
    step();
    tick_run(4, 1);
    t = t_run;
    goto(t + 2);
    i_run = 1'b1;
    i_num_cycle = 50;
    step();
    i_run = 1'b0;
    neg_at(t + 6);
    check("restart_idle", o_idle, 1);
    check("restart_count", o_cycle_count, 4);

    // Reset mid-run
    step();
    tick_run(20, 0);
    t = t_run;
    goto(t + 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("midrst_idle", o_idle, 1);
    check("midrst_core_en", o_core_en, 0);
    check("midrst_core_rst", o_core_rst, 1);
    check("midrst_count", o_cycle_count, 0);
    check("midrst_done", o_done, 0);
    check("midrst_err", o_wr_err, 0);

    repeat (5) step();
    @(negedge clk);
    check("wr_q_drained", exp_wr_q.size(), 0);
    check("done_q_drained", exp_done_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
